// File: rtl/disp_pkg.sv
// Shared encodings and helpers for the 4-digit multiplexed display scanner.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam int         DIGITS = 4;

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [3:0] an_for(input logic [1:0] s);
    an_for = ~(4'b0001 << s);
  endfunction

endpackage

// File: rtl/disp_src_arb.sv
// Display ownership arbiter: source B requests, is granted at a frame end,
// and keeps the display for at least HOLD_FRAMES frames.
module disp_src_arb #(
  parameter int HOLD_FRAMES = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic frame_tick,
  input  logic req_b,
  output logic gnt_b
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

  logic          gnt_reg, gnt_next;
  logic [HW-1:0] hold_reg, hold_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      gnt_reg  <= 1'b0;
      hold_reg <= '0;
    end else begin
      gnt_reg  <= gnt_next;
      hold_reg <= hold_next;
    end
  end

  always_comb begin
    gnt_next  = gnt_reg;
    hold_next = hold_reg;
    if (frame_tick) begin
      if (!gnt_reg) begin
        if (req_b) begin
          gnt_next  = 1'b1;
          hold_next = '0;
        end
      end else if (!req_b && (hold_reg == HOLD_MAX)) begin
        gnt_next = 1'b0;
      end else if (hold_reg != HOLD_MAX) begin
        hold_next = hold_reg + 1'b1;
      end
    end
  end

  assign gnt_b = gnt_reg;

endmodule

// File: rtl/disp_scan_ctrl.sv
// 4-digit 7-segment scan controller: dwell/blank sequencing, per-frame digit
// snapshot, leading-zero blanking for source A and A/B ownership arbitration.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DWELL       = 4096,
  parameter int BLANK_CYC   = 64,
  parameter int HOLD_FRAMES = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        en,
  input  logic        lzb_en,
  input  logic [15:0] dig_a,
  input  logic [15:0] dig_b,
  input  logic        req_b,
  output logic        gnt_b,
  output logic [3:0]  an,
  output logic [3:0]  digit_val,
  output logic        blank,
  output logic [1:0]  sel,
  output logic        frame_tick
);

  localparam int TMAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam bit NO_BLANK = (BLANK_CYC == 0);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  state_t        state_reg, state_next;
  logic [1:0]    sel_reg, sel_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [15:0]   snap_reg, snap_next;
  logic          lzb_reg, lzb_next;
  logic          load;

  logic [3:0]    an_reg, an_next;
  logic [3:0]    digit_val_reg, digit_val_next;
  logic          blank_reg, blank_next;
  logic          tick_reg, tick_next;

  logic [DIGITS-1:0] nz;
  logic [DIGITS-1:0] lzb_mask;

  // State and all outputs are registered together so outputs track the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      sel_reg       <= 2'd0;
      timer_reg     <= '0;
      snap_reg      <= 16'h0000;
      lzb_reg       <= 1'b0;
      an_reg        <= AN_OFF;
      digit_val_reg <= 4'd0;
      blank_reg     <= 1'b1;
      tick_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      timer_reg     <= timer_next;
      snap_reg      <= snap_next;
      lzb_reg       <= lzb_next;
      an_reg        <= an_next;
      digit_val_reg <= digit_val_next;
      blank_reg     <= blank_next;
      tick_reg      <= tick_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    timer_next = timer_reg;
    load       = 1'b0;
    if (!en) begin
      state_next = ST_IDLE;
      sel_next   = 2'd0;
      timer_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_DRIVE;
          sel_next   = 2'd0;
          timer_next = '0;
          load       = 1'b1;
        end
        ST_DRIVE: begin
          if (timer_reg == DWELL_LAST) begin
            timer_next = '0;
            if (NO_BLANK) begin
              sel_next = sel_reg + 2'd1;
              load     = (sel_reg == 2'd3);
            end else begin
              state_next = ST_BLANK;
            end
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        ST_BLANK: begin
          if (timer_reg == BLANK_LAST) begin
            state_next = ST_DRIVE;
            sel_next   = sel_reg + 2'd1;
            timer_next = '0;
            load       = (sel_reg == 2'd3);
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Snapshot the current owner at each digit-0 entry; gnt_b already reflects
  // the arbitration made on the preceding frame-end cycle.
  always_comb begin
    snap_next = snap_reg;
    lzb_next  = lzb_reg;
    if (load) begin
      snap_next = gnt_b ? dig_b : dig_a;
      lzb_next  = lzb_en & ~gnt_b;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lzb
      assign nz[gi] = |snap_next[4*gi +: 4];
      if (gi == 0) begin : g_d0
        assign lzb_mask[gi] = 1'b0;
      end else begin : g_dn
        assign lzb_mask[gi] = lzb_next & ~(|nz[DIGITS-1:gi]);
      end
    end
  endgenerate

  always_comb begin
    an_next        = (state_next == ST_DRIVE) ? an_for(sel_next) : AN_OFF;
    digit_val_next = snap_next[{sel_next, 2'b00} +: 4];
    blank_next     = (state_next != ST_DRIVE) | lzb_mask[sel_next];
    tick_next      = (sel_next == 2'd3) &&
                     ((!NO_BLANK && state_next == ST_BLANK && timer_next == BLANK_LAST) ||
                      ( NO_BLANK && state_next == ST_DRIVE && timer_next == DWELL_LAST));
  end

  // The arbiter sees the tick one cycle early so gnt_b changes in step with frame_tick.
  disp_src_arb #(
    .HOLD_FRAMES(HOLD_FRAMES)
  ) u_arb (
    .CLK        (CLK),
    .RST        (RST),
    .frame_tick (tick_next),
    .req_b      (req_b),
    .gnt_b      (gnt_b)
  );

  assign an         = an_reg;
  assign digit_val  = digit_val_reg;
  assign blank      = blank_reg;
  assign sel        = sel_reg;
  assign frame_tick = tick_reg;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl (DWELL=4, BLANK_CYC=2, HOLD_FRAMES=2) plus
// a BLANK_CYC=0 instance sharing the same stimulus.
module tb_disp_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RST, en, lzb_en, req_b;
  logic [15:0] dig_a, dig_b;

  logic        gnt_b, blank, frame_tick;
  logic [3:0]  an, digit_val;
  logic [1:0]  sel;

  logic        gnt_b0, blank0, frame_tick0;
  logic [3:0]  an0, digit_val0;
  logic [1:0]  sel0;

  int n_checks = 0;
  int n_fail   = 0;
  int gcyc     = 0;

  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 CLK = ~CLK;

  disp_scan_ctrl #(.DWELL(4), .BLANK_CYC(2), .HOLD_FRAMES(2)) dut (
    .CLK(CLK), .RST(RST), .en(en), .lzb_en(lzb_en), .dig_a(dig_a), .dig_b(dig_b),
    .req_b(req_b), .gnt_b(gnt_b), .an(an), .digit_val(digit_val), .blank(blank),
    .sel(sel), .frame_tick(frame_tick)
  );

  disp_scan_ctrl #(.DWELL(4), .BLANK_CYC(0), .HOLD_FRAMES(2)) dut0 (
    .CLK(CLK), .RST(RST), .en(en), .lzb_en(lzb_en), .dig_a(dig_a), .dig_b(dig_b),
    .req_b(req_b), .gnt_b(gnt_b0), .an(an0), .digit_val(digit_val0), .blank(blank0),
    .sel(sel0), .frame_tick(frame_tick0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    gcyc++;
  endtask

  // One 24-cycle frame: w/mask are the expected snapshot and LZB mask, gnt values
  // are expected before and on the tick cycle; new_* are applied mid-frame.
  task automatic run_frame(input int fr, input logic [15:0] w, input logic [3:0] mask,
                           input logic gnt_body, input logic gnt_tick,
                           input logic [15:0] new_a, input logic new_lzb,
                           input logic new_req, input logic [15:0] new_b);
    for (int p = 0; p < 24; p++) begin
      int d, r;
      step();
      d = p / 6;
      r = p % 6;
      chk($sformatf("f%0d p%0d an", fr, p), 32'(an), 32'((r < 4) ? an_tab[d] : 4'b1111));
      chk($sformatf("f%0d p%0d sel", fr, p), 32'(sel), 32'(d));
      chk($sformatf("f%0d p%0d tick", fr, p), 32'(frame_tick), 32'(p == 23));
      chk($sformatf("f%0d p%0d gnt", fr, p), 32'(gnt_b), 32'((p == 23) ? gnt_tick : gnt_body));
      if (r < 4) begin
        chk($sformatf("f%0d p%0d dval", fr, p), 32'(digit_val), 32'(w[4*d +: 4]));
        chk($sformatf("f%0d p%0d blank", fr, p), 32'(blank), 32'(mask[d]));
      end else begin
        chk($sformatf("f%0d p%0d blank", fr, p), 32'(blank), 32'(1));
      end
      if (gcyc < 48) begin
        chk($sformatf("nb g%0d an", gcyc), 32'(an0), 32'(an_tab[(gcyc / 4) % 4]));
        chk($sformatf("nb g%0d tick", gcyc), 32'(frame_tick0), 32'((gcyc % 16) == 15));
      end
      if (p == 13) begin
        dig_a  = new_a;
        lzb_en = new_lzb;
        req_b  = new_req;
        dig_b  = new_b;
      end
    end
    $display("frame %0d word %h gnt_end %b", fr, w, gnt_tick);
  endtask

  initial begin
    RST = 1'b1; en = 1'b0; lzb_en = 1'b0; req_b = 1'b0;
    dig_a = 16'h0000; dig_b = 16'h0000;

    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst%0d an", i), 32'(an), 32'(4'b1111));
    end
    chk("rst sel", 32'(sel), 32'(0));
    chk("rst dval", 32'(digit_val), 32'(0));
    chk("rst blank", 32'(blank), 32'(1));
    chk("rst gnt", 32'(gnt_b), 32'(0));
    chk("rst tick", 32'(frame_tick), 32'(0));

    RST = 1'b0; en = 1'b1; dig_a = 16'h1234;
    gcyc = -1;
    run_frame(1, 16'h1234, 4'b0000, 1'b0, 1'b0, 16'h5678, 1'b0, 1'b0, 16'h0000);
    run_frame(2, 16'h5678, 4'b0000, 1'b0, 1'b0, 16'h0042, 1'b1, 1'b0, 16'h0000);
    run_frame(3, 16'h0042, 4'b1100, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
    run_frame(4, 16'h0000, 4'b1110, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 16'hABCD);
    run_frame(5, 16'hABCD, 4'b0000, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 16'hABCD);
    run_frame(6, 16'hABCD, 4'b0000, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 16'hABCD);
    run_frame(7, 16'hABCD, 4'b0000, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'hABCD);
    run_frame(8, 16'h1234, 4'b0000, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 16'hABCD);

    // Frame 9: drop en mid digit 1 while B owns the display.
    req_b = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("f9 d1 an", 32'(an), 32'(4'b1101));
    chk("f9 d1 dval", 32'(digit_val), 32'(4'hC));
    en = 1'b0;
    step();
    chk("en0 an", 32'(an), 32'(4'b1111));
    chk("en0 sel", 32'(sel), 32'(0));
    chk("en0 blank", 32'(blank), 32'(1));
    chk("en0 gnt", 32'(gnt_b), 32'(1));
    for (int i = 0; i < 3; i++) step();
    chk("en0 hold an", 32'(an), 32'(4'b1111));
    chk("en0 hold gnt", 32'(gnt_b), 32'(1));
    chk("en0 hold tick", 32'(frame_tick), 32'(0));
    $display("en dropped: idle with gnt_b %b", gnt_b);

    en = 1'b1;
    step();
    chk("reen an", 32'(an), 32'(4'b1110));
    chk("reen sel", 32'(sel), 32'(0));
    chk("reen dval", 32'(digit_val), 32'(4'hD));
    chk("reen blank", 32'(blank), 32'(0));
    for (int i = 0; i < 12; i++) step();
    chk("d2 an", 32'(an), 32'(4'b1011));
    chk("d2 sel", 32'(sel), 32'(2));
    chk("d2 dval", 32'(digit_val), 32'(4'hB));
    chk("d2 gnt", 32'(gnt_b), 32'(1));

    RST = 1'b1;
    step();
    chk("mrst an", 32'(an), 32'(4'b1111));
    chk("mrst sel", 32'(sel), 32'(0));
    chk("mrst dval", 32'(digit_val), 32'(0));
    chk("mrst blank", 32'(blank), 32'(1));
    chk("mrst gnt", 32'(gnt_b), 32'(0));
    chk("mrst tick", 32'(frame_tick), 32'(0));
    $display("mid-frame reset applied");
    RST = 1'b0; en = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
